// File: rtl/wbl_pkg.sv
// -----------------------------------------------------------------------------
// wbl_pkg
// Shared definitions for weight_bank_loader and its bank sub-module:
//   - wbl_state_e         : loader FSM states (IDLE / LOAD / COMMIT)
//   - calc_max_bits()     : bits held by one output channel (K_max^2 * W)
//   - calc_beats_max()    : bus beats needed for the largest kernel
//   - calc_ch_w()         : shadow register width per channel (whole beats)
//   - beats_per_channel() : bus beats needed for a runtime kernel edge K
// -----------------------------------------------------------------------------
package wbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } wbl_state_e;

  function automatic int calc_max_bits(input int max_kernel, input int weight_width);
    return max_kernel * max_kernel * weight_width;
  endfunction

  function automatic int calc_beats_max(input int max_bits, input int bus_width);
    return (max_bits + bus_width - 1) / bus_width;
  endfunction

  function automatic int calc_ch_w(input int beats_max, input int bus_width);
    return beats_max * bus_width;
  endfunction

  // Ceiling division of the channel payload by the bus width. bus_width is an
  // elaboration constant, so this maps to a small constant divider on K.
  function automatic int beats_per_channel(input int k, input int weight_width,
                                           input int bus_width);
    return (k * k * weight_width + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/wbl_bank.sv
// -----------------------------------------------------------------------------
// wbl_bank
// Double-buffered weight storage. The shadow bank (NUM_CH x CH_W) is filled
// one bus beat at a time, MSB-first; the active bank (NUM_CH x MAX_BITS) only
// changes on a commit strobe, so it stays stable while the shadow refills.
//
// Ports
//   clk, rstn      : clock, asynchronous active-low reset
//   clear_i        : zero the whole shadow bank
//   wr_en_i        : write wr_data_i as beat wr_beat_i of channel wr_ch_i
//   wr_ch_i        : target channel of the write
//   wr_beat_i      : beat index within the channel (0 = most significant)
//   wr_data_i      : beat payload
//   commit_i       : copy shadow into active bank
//   commit_ch_i    : number of channels being committed; higher ones are zeroed
//   commit_mask_i  : keeps only the top K^2*W payload bits of each channel
//   active_o       : flattened active bank, channel c at [c*MAX_BITS +: MAX_BITS]
// -----------------------------------------------------------------------------
module wbl_bank
  import wbl_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BUS_WIDTH = 32,
  parameter int MAX_BITS  = 200
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 clear_i,
  input  logic                                 wr_en_i,
  input  logic [$clog2(NUM_CH+1)-1:0]          wr_ch_i,
  input  logic [$clog2(calc_beats_max(MAX_BITS, BUS_WIDTH)+1)-1:0] wr_beat_i,
  input  logic [BUS_WIDTH-1:0]                 wr_data_i,
  input  logic                                 commit_i,
  input  logic [$clog2(NUM_CH+1)-1:0]          commit_ch_i,
  input  logic [MAX_BITS-1:0]                  commit_mask_i,
  output logic [NUM_CH*MAX_BITS-1:0]           active_o
);

  localparam int BEATS_MAX = calc_beats_max(MAX_BITS, BUS_WIDTH);
  localparam int CH_W      = calc_ch_w(BEATS_MAX, BUS_WIDTH);
  localparam int CH_CNT_W  = $clog2(NUM_CH + 1);
  localparam int BEAT_W    = $clog2(BEATS_MAX + 1);

  logic [CH_W-1:0]     shadow_q [NUM_CH];
  logic [MAX_BITS-1:0] active_q [NUM_CH];

  // NOTE: both banks are ordinary flops with a reset, not RAM macros; the
  // loader must come out of reset with a defined all-zero weight set, and a
  // mid-load reset is required to wipe the active bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
    end else if (wr_en_i) begin
      // Beat b lands b bus-widths below the top of the channel register.
      for (int c = 0; c < NUM_CH; c++) begin
        for (int b = 0; b < BEATS_MAX; b++) begin
          if (wr_ch_i == CH_CNT_W'(c) && wr_beat_i == BEAT_W'(b)) begin
            shadow_q[c][CH_W-1-b*BUS_WIDTH -: BUS_WIDTH] <= wr_data_i;
          end
        end
      end
    end
  end

  // Payload beyond MAX_BITS in the final beat is dropped here by taking only
  // the top MAX_BITS of each shadow channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) active_q[c] <= '0;
    end else if (commit_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (CH_CNT_W'(c) < commit_ch_i) begin
          active_q[c] <= shadow_q[c][CH_W-1 -: MAX_BITS] & commit_mask_i;
        end else begin
          active_q[c] <= '0;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_flat
    assign active_o[c*MAX_BITS +: MAX_BITS] = active_q[c];
  end

  // The shadow bits below MAX_BITS are written but never committed.
  logic unused_shadow;
  always_comb begin
    unused_shadow = 1'b0;
    for (int c = 0; c < NUM_CH; c++) unused_shadow = unused_shadow ^ (^shadow_q[c]);
  end

endmodule

// File: rtl/weight_bank_loader.sv
// -----------------------------------------------------------------------------
// weight_bank_loader
// Receives convolution weights over an AXI4-Stream slave and packs them
// MSB-first into per-output-channel weight registers. Kernel edge K and
// channel count C are set per load. A shadow bank is filled while the active
// bank keeps driving the MAC array; the two are swapped atomically in COMMIT.
//
// Optional feature macro: WBL_TLAST_CHECK_EN
//   defined   : tlast must mark exactly the final beat; a mismatch sets the
//               sticky tlast_err, and an early tlast aborts the load.
//   undefined : s_axis_tlast is ignored, tlast_err is constant 0.
//
// Ports
//   clk, rstn      : clock, asynchronous active-low reset
//   cfg_kernel     : kernel edge K (1..MAX_KERNEL), sampled on start
//   cfg_num_ch     : channel count C (1..NUM_CH), sampled on start
//   start          : begin a load (only honoured in IDLE)
//   s_axis_*       : AXI4-Stream weight input; tready is high throughout LOAD
//   weights_out    : active bank, channel c at [c*MAX_BITS +: MAX_BITS]
//   weights_valid  : active bank holds a committed set
//   loading        : high in LOAD and COMMIT
//   done           : one-cycle pulse when a load commits
//   cfg_err        : one-cycle pulse when start carries an illegal K or C
//   tlast_err      : sticky tlast protocol error, cleared by the next start
// -----------------------------------------------------------------------------
module weight_bank_loader
  import wbl_pkg::*;
#(
  parameter int MAX_KERNEL   = 5,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BUS_WIDTH    = 32,
  parameter int NUM_CH       = 4
) (
  input  logic                                               clk,
  input  logic                                               rstn,
  input  logic [2:0]                                         cfg_kernel,
  input  logic [$clog2(NUM_CH+1)-1:0]                        cfg_num_ch,
  input  logic                                               start,
  input  logic [BUS_WIDTH-1:0]                               s_axis_tdata,
  input  logic                                               s_axis_tvalid,
  input  logic                                               s_axis_tlast,
  output logic                                               s_axis_tready,
  output logic [NUM_CH*MAX_KERNEL*MAX_KERNEL*WEIGHT_WIDTH-1:0] weights_out,
  output logic                                               weights_valid,
  output logic                                               loading,
  output logic                                               done,
  output logic                                               cfg_err,
  output logic                                               tlast_err
);

  localparam int MAX_BITS  = calc_max_bits(MAX_KERNEL, WEIGHT_WIDTH);
  localparam int BEATS_MAX = calc_beats_max(MAX_BITS, BUS_WIDTH);
  localparam int CH_CNT_W  = $clog2(NUM_CH + 1);
  localparam int BEAT_W    = $clog2(BEATS_MAX + 1);
  localparam int KBITS_W   = $clog2(MAX_BITS + 1);

  wbl_state_e          state_q;
  logic [BEAT_W-1:0]   bpc_q;       // beats per channel for this load
  logic [CH_CNT_W-1:0] num_ch_q;    // C latched on start
  logic [KBITS_W-1:0]  kbits_q;     // K^2 * WEIGHT_WIDTH latched on start
  logic [BEAT_W-1:0]   beat_q;
  logic [CH_CNT_W-1:0] ch_q;
  logic                tready_q;
  logic                loading_q;
  logic                done_q;
  logic                cfg_err_q;
  logic                tlast_err_q;
  logic                weights_valid_q;

  logic                cfg_ok;
  logic [BEAT_W-1:0]   bpc_d;
  logic [KBITS_W-1:0]  kbits_d;
  logic                beat_fire;
  logic                end_of_ch;
  logic                last_beat;
  logic                tlast_early;
  logic                tlast_missing;
  logic [MAX_BITS-1:0] commit_mask;

  // ---------------------------------------------------------------------------
  // Start decode and per-beat conditions
  // ---------------------------------------------------------------------------
  assign cfg_ok = (cfg_kernel != 3'd0) && (int'(cfg_kernel) <= MAX_KERNEL) &&
                  (cfg_num_ch != '0)   && (int'(cfg_num_ch) <= NUM_CH);

  assign bpc_d   = BEAT_W'(beats_per_channel(int'(cfg_kernel), WEIGHT_WIDTH, BUS_WIDTH));
  assign kbits_d = KBITS_W'(int'(cfg_kernel) * int'(cfg_kernel) * WEIGHT_WIDTH);

  // tready_q is only ever high in LOAD, so it doubles as the state qualifier.
  assign beat_fire = tready_q && s_axis_tvalid;
  assign end_of_ch = (beat_q == bpc_q - BEAT_W'(1));
  assign last_beat = end_of_ch && (ch_q == num_ch_q - CH_CNT_W'(1));

`ifdef WBL_TLAST_CHECK_EN
  assign tlast_early   = beat_fire &&  s_axis_tlast && !last_beat;
  assign tlast_missing = beat_fire && !s_axis_tlast &&  last_beat;
`else
  assign tlast_early   = 1'b0;
  assign tlast_missing = 1'b0;
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  // Keep the top K^2*W bits of each channel slice; the rest of the last beat
  // is padding and must read back as zero.
  // NOTE: every always_comb output is given a default before any conditional
  // logic so no path can leave it unassigned and infer a latch.
  always_comb begin
    commit_mask = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      commit_mask[i] = (i >= MAX_BITS - int'(kbits_q));
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      bpc_q           <= '0;
      num_ch_q        <= '0;
      kbits_q         <= '0;
      beat_q          <= '0;
      ch_q            <= '0;
      tready_q        <= 1'b0;
      loading_q       <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
      tlast_err_q     <= 1'b0;
      weights_valid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q     <= ST_LOAD;
              bpc_q       <= bpc_d;
              num_ch_q    <= cfg_num_ch;
              kbits_q     <= kbits_d;
              beat_q      <= '0;
              ch_q        <= '0;
              tready_q    <= 1'b1;
              loading_q   <= 1'b1;
              tlast_err_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (beat_fire) begin
            if (tlast_early) begin
              // Abandon the load; the active bank is left untouched.
              state_q     <= ST_IDLE;
              tready_q    <= 1'b0;
              loading_q   <= 1'b0;
              tlast_err_q <= 1'b1;
            end else begin
              if (tlast_missing) tlast_err_q <= 1'b1;
              if (last_beat) begin
                state_q  <= ST_COMMIT;
                tready_q <= 1'b0;
              end else if (end_of_ch) begin
                beat_q <= '0;
                ch_q   <= ch_q + CH_CNT_W'(1);
              end else begin
                beat_q <= beat_q + BEAT_W'(1);
              end
            end
          end
        end

        ST_COMMIT: begin
          state_q         <= ST_IDLE;
          loading_q       <= 1'b0;
          done_q          <= 1'b1;
          weights_valid_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage
  // ---------------------------------------------------------------------------
  wbl_bank #(
    .NUM_CH    (NUM_CH),
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_BITS  (MAX_BITS)
  ) u_bank (
    .clk           (clk),
    .rstn          (rstn),
    .clear_i       ((state_q == ST_IDLE) && start && cfg_ok),
    .wr_en_i       (beat_fire),
    .wr_ch_i       (ch_q),
    .wr_beat_i     (beat_q),
    .wr_data_i     (s_axis_tdata),
    .commit_i      (state_q == ST_COMMIT),
    .commit_ch_i   (num_ch_q),
    .commit_mask_i (commit_mask),
    .active_o      (weights_out)
  );

  assign s_axis_tready = tready_q;
  assign loading       = loading_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign tlast_err     = tlast_err_q;
  assign weights_valid = weights_valid_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_bank_loader
// Self-checking bench for weight_bank_loader (default parameters). Random
// beats are fed over AXI-Stream; the expected active bank is rebuilt from the
// accepted beat list by plain bit arithmetic. Honours WBL_TLAST_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_weight_bank_loader;

  localparam int MK = 5;
  localparam int WW = 8;
  localparam int BW = 32;
  localparam int NC = 4;
  localparam int MB = MK * MK * WW;   // 200
  localparam int OW = NC * MB;        // 800

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    cfg_kernel;
  logic [2:0]    cfg_num_ch;
  logic          start;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [OW-1:0] weights_out;
  logic          weights_valid;
  logic          loading;
  logic          done;
  logic          cfg_err;
  logic          tlast_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [OW-1:0] model_active;

  always #5 clk = ~clk;

  weight_bank_loader dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_kernel    (cfg_kernel),
    .cfg_num_ch    (cfg_num_ch),
    .start         (start),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .weights_out   (weights_out),
    .weights_valid (weights_valid),
    .loading       (loading),
    .done          (done),
    .cfg_err       (cfg_err),
    .tlast_err     (tlast_err)
  );

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel ch's stream is the concatenation of its beats, MSB of beat 0
  // first; its first K^2*W bits occupy the top of the channel slice.
  function automatic logic [OW-1:0] expected_bank(input int k, input int c,
                                                  input logic [BW-1:0] beats[$]);
    logic [OW-1:0] r;
    int bpc;
    r   = '0;
    bpc = (k * k * WW + BW - 1) / BW;
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < k * k * WW; i++)
        r[ch*MB + MB - 1 - i] = beats[ch*bpc + i/BW][BW - 1 - i%BW];
    return r;
  endfunction

  // One load. early_idx >= 0 puts tlast on that beat (abort expected with the
  // tlast check on); drop_last withholds tlast on the final beat; watch_old
  // checks the active bank every cycle of the load.
  task automatic do_load(input int k, input int c, input bit gaps,
                         input int early_idx, input bit drop_last, input bit watch_old);
    logic [BW-1:0] beats[$];
    logic [OW-1:0] old;
    int bpc, total, idx, cyc, tv_cnt, n_done;
    bpc    = (k * k * WW + BW - 1) / BW;
    total  = c * bpc;
    old    = model_active;
    idx    = 0;
    cyc    = 0;
    tv_cnt = 0;

    @(negedge clk);
    cfg_kernel = 3'(k);
    cfg_num_ch = 3'(c);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("tready_after_start", s_axis_tready, 1);

    while (idx < total && cyc < 4000) begin
      s_axis_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = $urandom;
`ifdef WBL_TLAST_CHECK_EN
      s_axis_tlast  = ((idx == total - 1) && !drop_last) || (idx == early_idx);
`else
      s_axis_tlast  = 1'($urandom_range(0, 1));
`endif
      if (s_axis_tvalid) tv_cnt++;
      if (s_axis_tvalid && s_axis_tready) begin
        beats.push_back(s_axis_tdata);
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (watch_old && idx < total) check("bank_stable_during_load", weights_out, old);
`ifdef WBL_TLAST_CHECK_EN
      if (early_idx >= 0 && idx > early_idx) break;
`endif
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("no_backpressure", idx, tv_cnt);

`ifdef WBL_TLAST_CHECK_EN
    if (early_idx >= 0) begin
      check("abort_beats", idx, early_idx + 1);
      check("abort_tready", s_axis_tready, 0);
      check("abort_loading", loading, 0);
      check("abort_tlast_err", tlast_err, 1);
      n_done = 0;
      repeat (4) begin
        if (done) n_done++;
        @(negedge clk);
      end
      check("abort_no_done", n_done, 0);
      check("abort_bank_kept", weights_out, model_active);
      return;
    end
`endif

    check("beats_accepted", idx, total);
    // Cycle after the final handshake: COMMIT, old bank still visible.
    check("commit_no_done_yet", done, 0);
    check("commit_loading", loading, 1);
    check("commit_tready_low", s_axis_tready, 0);
    check("commit_old_bank", weights_out, old);
    model_active = expected_bank(k, c, beats);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("loading_off", loading, 0);
    check("weights_out", weights_out, model_active);
    check("weights_valid", weights_valid, 1);
`ifdef WBL_TLAST_CHECK_EN
    check("tlast_err", tlast_err, drop_last);
`else
    check("tlast_err_tied", tlast_err, 0);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic bad_start(input int k, input int c);
    @(negedge clk);
    cfg_kernel = 3'(k);
    cfg_num_ch = 3'(c);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_tready", s_axis_tready, 0);
    check("cfg_err_loading", loading, 0);
    @(negedge clk);
    check("cfg_err_clears", cfg_err, 0);
    check("cfg_err_tready_stays", s_axis_tready, 0);
    check("cfg_err_bank_kept", weights_out, model_active);
  endtask

  initial begin
    rstn          = 1'b0;
    cfg_kernel    = '0;
    cfg_num_ch    = '0;
    start         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    model_active  = '0;

    #22;
    check("rst_tready", s_axis_tready, 0);
    check("rst_weights", weights_out, 0);
    check("rst_valid", weights_valid, 0);
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_tlast_err", tlast_err, 0);
    @(negedge clk);
    rstn = 1'b1;

    do_load(3, 1, 1'b0, -1, 1'b0, 1'b0);
    do_load(5, 4, 1'b1, -1, 1'b0, 1'b0);
    do_load(2, 2, 1'b1, -1, 1'b0, 1'b0);
    do_load(4, 1, 1'b0, -1, 1'b0, 1'b1);

    bad_start(6, 1);
    bad_start(3, 0);
    bad_start(0, 2);

`ifdef WBL_TLAST_CHECK_EN
    do_load(4, 2, 1'b0, 2, 1'b0, 1'b0);
    do_load(4, 2, 1'b0, -1, 1'b1, 1'b0);
    do_load(3, 2, 1'b1, -1, 1'b0, 1'b0);
`endif

    repeat (5) begin
      do_load(int'($urandom_range(1, MK)), int'($urandom_range(1, NC)),
              1'($urandom_range(0, 1)), -1, 1'b0, 1'b1);
    end

    // Asynchronous reset in the middle of a K=5, C=2 load.
    @(negedge clk);
    cfg_kernel = 3'd5;
    cfg_num_ch = 3'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = $urandom;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    check("midload_loading", loading, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_tready", s_axis_tready, 0);
    check("async_rst_weights", weights_out, 0);
    check("async_rst_valid", weights_valid, 0);
    check("async_rst_loading", loading, 0);
    check("async_rst_done", done, 0);
    check("async_rst_tlast_err", tlast_err, 0);
    model_active = '0;
    @(negedge clk);
    rstn = 1'b1;
    do_load(5, 2, 1'b1, -1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_bank_loader.md
# weight_bank_loader

Multi-channel, double-buffered successor to `weight_loader`: receives convolution weights over an AXI4-Stream slave and packs them MSB-first into per-output-channel weight registers for the MAC array. Kernel size and channel count are runtime-configurable up to compile-time maxima. A shadow bank is filled while the active bank keeps driving the datapath, and the two are committed atomically.

## Interface
- `MAX_KERNEL`, 5: largest supported kernel edge.
- `WEIGHT_WIDTH`, 8: bits per weight.
- `BUS_WIDTH`, 32: AXIS data width.
- `NUM_CH`, 4: maximum output channels.
- Derived: `MAX_BITS = MAX_KERNEL²·WEIGHT_WIDTH`; `BEATS_MAX = ceil(MAX_BITS/BUS_WIDTH)`; `CH_W = BEATS_MAX·BUS_WIDTH`.

- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cfg_kernel` in 3: kernel edge K, legal range 1..MAX_KERNEL; sampled on `start`.
- `cfg_num_ch` in clog2(NUM_CH+1): channel count C, legal range 1..NUM_CH; sampled on `start`.
- `start` in 1: begins a load when in IDLE.
- `s_axis_tdata` in BUS_WIDTH: weight beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: marks the final beat of the load.
- `s_axis_tready` out 1: beat accepted when high with tvalid.
- `weights_out` out NUM_CH·MAX_BITS: active bank; channel c is `[(c+1)·MAX_BITS-1 : c·MAX_BITS]`.
- `weights_valid` out 1: active bank holds a committed set.
- `loading` out 1: high in LOAD and COMMIT.
- `done` out 1: one-cycle pulse on commit.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `tlast_err` out 1: sticky; cleared by the next accepted `start`.

## Operation
- States are IDLE, LOAD and COMMIT. The state is registered.
- IDLE → LOAD on `start` with legal K and C:
  - latch K and C;
  - compute `BPC = ceil(K²·WEIGHT_WIDTH/BUS_WIDTH)`;
  - zero the shadow bank;
  - zero the beat and channel counters.
- Illegal cfg on `start` (K=0, K>MAX_KERNEL, C=0, C>NUM_CH): pulse `cfg_err` and stay in IDLE.
- `start` outside IDLE is ignored.
- LOAD behaviour:
  - `s_axis_tready` = 1.
  - Each handshake writes beat b of channel ch into `shadow[ch][CH_W-1-b·BUS_WIDTH -: BUS_WIDTH]`, MSB-first.
  - The beat counter wraps at BPC-1 and then increments ch.
  - The handshake on beat BPC-1 of channel C-1 → COMMIT.
- COMMIT (one cycle):
  - for each channel, active[c] ← `shadow[c][CH_W-1 -: MAX_BITS]`; channels ≥C are written with zero;
  - `weights_valid` ← 1 and `done` pulses;
  - → IDLE.
- Bits below K²·WEIGHT_WIDTH within a channel slice are zero-padded. Payload bits in the last beat beyond MAX_BITS are discarded.
- The active bank is never modified outside COMMIT, so it stays stable throughout a following load.

## Timing
- Reset values: state IDLE; `s_axis_tready`, `loading`, `done`, `cfg_err`, `tlast_err` and `weights_valid` = 0; both banks and all counters 0.
- `s_axis_tready` is decoded from the registered state only and has no combinational path from tvalid.
- `start` at edge n gives `s_axis_tready`=1 from cycle n+1.
- Final handshake at edge m gives COMMIT during cycle m+1, with `done`=1 and the new `weights_out` visible after edge m+1. `loading` is 0 from cycle m+2.
- A new `start` is accepted in cycle m+2 at the earliest.
- Throughput is one beat per cycle. Total load latency is C·BPC+1 cycles after the first handshake when tvalid is held high.
- tvalid gaps stall the counters. No timeout.
- `rstn` asserted mid-load: immediate abort, all state cleared, the active bank is lost.

## Configuration
- `WBL_TLAST_CHECK_EN` defined:
  - `tlast`=0 on the expected final beat, or `tlast`=1 on any other beat, sets `tlast_err`;
  - an early `tlast` aborts the load: → IDLE with no commit, and the active bank is unchanged.
- `WBL_TLAST_CHECK_EN` undefined: `s_axis_tlast` is ignored and `tlast_err` is tied to 0.

## Structure
- Package `wbl_pkg`:
  - state enum (IDLE/LOAD/COMMIT);
  - the `MAX_BITS`, `BEATS_MAX` and `CH_W` calculation functions;
  - the `beats_per_channel(K)` function.
- One sub-module, `wbl_bank`: NUM_CH×CH_W shadow registers with beat-indexed write and clear, plus the active bank with a commit strobe.

## Test plan
- Defaults, K=3, C=1, 3 random beats: `weights_out[199:128]` equals the top 72 bits of the concatenated beats, bits [127:0] are zero, `done` pulses once, and `weights_valid`=1.
- K=5, C=4, 28 beats with tvalid toggling randomly: each channel slice equals the top 200 bits of its 7 beats, and total cycles ≥ 29.
- K=2, C=2 committed, then start K=4, C=1: `weights_out` holds the K=2 values until the cycle after the last handshake, then shows the K=4 values with channel 1 zeroed.
- `start` with K=6, then with C=0: `cfg_err` pulses twice, state stays IDLE, and `s_axis_tready` stays 0.
- With `WBL_TLAST_CHECK_EN`, K=4, C=2, `tlast` on beat 2: `tlast_err`=1, no `done`, and the active bank is unchanged. Repeat with no `tlast` on the final beat: commit occurs and `tlast_err`=1.
- `rstn` pulsed low after beat 3 of a K=5, C=2 load: all outputs return to reset values asynchronously, and a subsequent full load commits correctly.
